// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// datapath width, iteration counter width, FSM states and Op encodings.
package riscv_pkg;

    localparam int L  = 16;
    localparam int CW = $clog2(L) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decode/register-file side bus of the multiply/divide sequencer.
// The master drives requests; the slave (sequencer) returns stall and results.
interface muldiv_sequencer_if;
    import riscv_pkg::*;

    logic         Start;
    logic         Op;
    logic [L-1:0] OperandB;
    logic [L-1:0] OperandC;
    logic         Stall;
    logic         WriteEnable;
    logic [L-1:0] ResultLo;
    logic [L-1:0] ResultHi;
    logic         Zero;
    logic         DivByZero;

    modport master (
        output Start, Op, OperandB, OperandC,
        input  Stall, WriteEnable, ResultLo, ResultHi, Zero, DivByZero
    );

    modport slave (
        input  Start, Op, OperandB, OperandC,
        output Stall, WriteEnable, ResultLo, ResultHi, Zero, DivByZero
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on the {acc, shift register} pair.
module muldiv_step
    import riscv_pkg::*;
(
    input  logic         op_i,
    input  logic [L:0]   acc_i,
    input  logic [L-1:0] sr_i,
    input  logic [L-1:0] operand_i,
    output logic [L:0]   acc_o,
    output logic [L-1:0] sr_o
);

    logic [L:0]   mul_sum;
    logic [L:0]   div_shift;
    logic [L+1:0] div_diff;

    always_comb begin
        mul_sum   = sr_i[0] ? (acc_i + {1'b0, operand_i}) : acc_i;
        div_shift = {acc_i[L-1:0], sr_i[L-1]};
        // Extra top bit of the difference is the borrow of the trial subtract.
        div_diff  = {1'b0, div_shift} - {2'b00, operand_i};

        if (op_i == OP_MUL) begin
            acc_o = {1'b0, mul_sum[L:1]};
            sr_o  = {mul_sum[0], sr_i[L-1:1]};
        end else if (!div_diff[L+1]) begin
            acc_o = div_diff[L:0];
            sr_o  = {sr_i[L-2:0], 1'b1};
        end else begin
            acc_o = div_shift;
            sr_o  = {sr_i[L-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer. States: IDLE waits for Start,
// RUN iterates L steps, DONE presents registered results with WriteEnable.
module muldiv_sequencer
    import riscv_pkg::*;
(
    input logic               Clk,
    input logic               ResetN,
    muldiv_sequencer_if.slave bus
);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          op_q;
    logic [L-1:0]  operand_q;
    logic [L:0]    acc_q;
    logic [L-1:0]  sr_q;
    logic [L-1:0]  res_lo_q;
    logic [L-1:0]  res_hi_q;
    logic          zero_q;
    logic          dbz_q;
    logic          we_q;

    logic [L:0]    acc_d;
    logic [L-1:0]  sr_d;
    logic          div_zero;

    assign div_zero = (bus.Op == OP_DIV) && (bus.OperandC == '0);

    muldiv_step u_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .sr_i      (sr_q),
        .operand_i (operand_q),
        .acc_o     (acc_d),
        .sr_o      (sr_d)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            operand_q <= '0;
            acc_q     <= '0;
            sr_q      <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            zero_q    <= 1'b0;
            dbz_q     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        op_q  <= bus.Op;
                        acc_q <= '0;
                        // Multiplier / dividend go into the shift register.
                        if (bus.Op == OP_MUL) begin
                            operand_q <= bus.OperandB;
                            sr_q      <= bus.OperandC;
                        end else begin
                            operand_q <= bus.OperandC;
                            sr_q      <= bus.OperandB;
                        end
                        if (div_zero) begin
                            state_q  <= DONE;
                            we_q     <= 1'b1;
                            res_lo_q <= '1;
                            res_hi_q <= bus.OperandB;
                            zero_q   <= 1'b0;
                            dbz_q    <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            cnt_q   <= CW'(L - 1);
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    sr_q  <= sr_d;
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        we_q     <= 1'b1;
                        res_lo_q <= sr_d;
                        res_hi_q <= acc_d[L-1:0];
                        zero_q   <= (op_q == OP_MUL) ? ({acc_d[L-1:0], sr_d} == '0)
                                                     : (sr_d == '0);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall must rise in the request cycle itself, so it cannot be registered.
    assign bus.Stall       = ResetN && ((state_q == IDLE && bus.Start) || state_q == RUN);
    assign bus.WriteEnable = we_q;
    assign bus.ResultLo    = res_lo_q;
    assign bus.ResultHi    = res_hi_q;
    assign bus.Zero        = zero_q;
    assign bus.DivByZero   = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed scenarios plus random
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
    import riscv_pkg::*;

    logic Clk = 1'b0;
    logic ResetN;
    int   vectors = 0;
    int   miscompares = 0;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    // Called #1 after a rising edge with the FSM idle; that cycle is cycle 0.
    // Returns #1 after the rising edge that ends DONE, with Start still high.
    task automatic run_op(input logic op, input logic [15:0] b, input logic [15:0] c,
                          input string name);
        logic [31:0] p;
        logic [15:0] exp_lo, exp_hi;
        logic        exp_z, exp_dbz;
        int          done_cyc;
        if (op == OP_MUL) begin
            p        = 32'(b) * 32'(c);
            exp_lo   = p[15:0];
            exp_hi   = p[31:16];
            exp_z    = (p == 32'd0);
            exp_dbz  = 1'b0;
            done_cyc = 17;
        end else if (c == 16'd0) begin
            exp_lo   = 16'hFFFF;
            exp_hi   = b;
            exp_z    = 1'b0;
            exp_dbz  = 1'b1;
            done_cyc = 1;
        end else begin
            exp_lo   = b / c;
            exp_hi   = b % c;
            exp_z    = (exp_lo == 16'd0);
            exp_dbz  = 1'b0;
            done_cyc = 17;
        end
        bus.Start    = 1'b1;
        bus.Op       = op;
        bus.OperandB = b;
        bus.OperandC = c;
        for (int cyc = 0; cyc <= done_cyc; cyc++) begin
            @(negedge Clk);
            vectors++;
            if (bus.Stall !== (cyc < done_cyc)) begin
                miscompares++;
                $display("FAIL %s stall cyc %0d: got %b want %b", name, cyc, bus.Stall, cyc < done_cyc);
            end
            vectors++;
            if (bus.WriteEnable !== (cyc == done_cyc)) begin
                miscompares++;
                $display("FAIL %s write_enable cyc %0d: got %b want %b", name, cyc, bus.WriteEnable, cyc == done_cyc);
            end
            if (cyc == done_cyc) begin
                vectors++;
                if (bus.ResultLo !== exp_lo) begin
                    miscompares++;
                    $display("FAIL %s result_lo: got %h want %h (b=%h c=%h)", name, bus.ResultLo, exp_lo, b, c);
                end
                vectors++;
                if (bus.ResultHi !== exp_hi) begin
                    miscompares++;
                    $display("FAIL %s result_hi: got %h want %h (b=%h c=%h)", name, bus.ResultHi, exp_hi, b, c);
                end
                vectors++;
                if (bus.Zero !== exp_z) begin
                    miscompares++;
                    $display("FAIL %s zero: got %b want %b", name, bus.Zero, exp_z);
                end
                vectors++;
                if (bus.DivByZero !== exp_dbz) begin
                    miscompares++;
                    $display("FAIL %s div_by_zero: got %b want %b", name, bus.DivByZero, exp_dbz);
                end
            end
            @(posedge Clk);
            #1;
            if (cyc >= 1 && cyc < done_cyc) begin
                bus.Op       = 1'($urandom);
                bus.OperandB = 16'($urandom);
                bus.OperandC = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        ResetN       = 1'b0;
        bus.Start    = 1'b1;
        bus.Op       = OP_MUL;
        bus.OperandB = 16'd3;
        bus.OperandC = 16'd4;
        repeat (2) @(negedge Clk);
        vectors++;
        if (bus.Stall !== 1'b0 || bus.WriteEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset stall/we: got %b/%b want 0/0", bus.Stall, bus.WriteEnable);
        end
        vectors++;
        if (bus.ResultLo !== 16'd0 || bus.ResultHi !== 16'd0 || bus.Zero !== 1'b0 || bus.DivByZero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset results: got %h %h %b %b want 0 0 0 0",
                     bus.ResultLo, bus.ResultHi, bus.Zero, bus.DivByZero);
        end
        bus.Start = 1'b0;
        ResetN    = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_directed();
        run_op(OP_MUL, 16'd300, 16'd300, "mul_300x300");
        bus.Start = 1'b0;
        run_op(OP_DIV, 16'd1000, 16'd7, "div_1000_7");
        bus.Start = 1'b0;
        run_op(OP_DIV, 16'd1234, 16'd0, "div_1234_0");
        bus.Start = 1'b0;
        run_op(OP_MUL, 16'd2, 16'd3, "mul_2x3_after_dbz");
        bus.Start = 1'b0;
        run_op(OP_MUL, 16'd0, 16'hFFFF, "mul_zero");
        bus.Start = 1'b0;
        run_op(OP_DIV, 16'd5, 16'd9, "div_zero_quot");
        bus.Start = 1'b0;
        run_op(OP_MUL, 16'hFFFF, 16'hFFFF, "mul_max");
        bus.Start = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_op(OP_MUL, 16'd5, 16'd7, "hold_first");
        run_op(OP_DIV, 16'd9, 16'd2, "hold_second");
        bus.Start = 1'b0;
    endtask

    task automatic test_reset_abort();
        bus.Start    = 1'b1;
        bus.Op       = OP_MUL;
        bus.OperandB = 16'd1234;
        bus.OperandC = 16'd567;
        repeat (8) @(posedge Clk);
        #1;
        ResetN = 1'b0;
        #1;
        vectors++;
        if (bus.Stall !== 1'b0 || bus.WriteEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL abort stall/we: got %b/%b want 0/0", bus.Stall, bus.WriteEnable);
        end
        vectors++;
        if (bus.ResultLo !== 16'd0 || bus.ResultHi !== 16'd0 || bus.Zero !== 1'b0 || bus.DivByZero !== 1'b0) begin
            miscompares++;
            $display("FAIL abort results: got %h %h %b %b want 0 0 0 0",
                     bus.ResultLo, bus.ResultHi, bus.Zero, bus.DivByZero);
        end
        bus.Start = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            vectors++;
            if (bus.WriteEnable !== 1'b0 || bus.Stall !== 1'b0) begin
                miscompares++;
                $display("FAIL abort idle cyc %0d: we=%b stall=%b want 0/0", i, bus.WriteEnable, bus.Stall);
            end
        end
        @(posedge Clk);
        #1;
        run_op(OP_MUL, 16'd1234, 16'd567, "after_abort");
        bus.Start = 1'b0;
    endtask

    task automatic test_random();
        logic        op;
        logic [15:0] b, c;
        for (int n = 0; n < 24; n++) begin
            op = 1'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 50)) : 16'($urandom);
            if ($urandom_range(0, 4) == 0)
                c = 16'd0;
            else if ($urandom_range(0, 1) == 1)
                c = 16'($urandom_range(1, 40));
            else
                c = 16'($urandom);
            run_op(op, b, c, "random");
            if ($urandom_range(0, 1) == 1) begin
                bus.Start = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge Clk);
                    #1;
                end
            end
        end
        bus.Start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
